axi4lite_ipif: RTL and testbench

AXI4-Lite slave to simple IP-interface (IPIF) bridge. Converts AXI4-Lite write and read transactions into single-cycle request pulses on a word-addressed register bus, then returns the user's acknowledge as an AXI response. It sits between the interconnect and a block's register file. Read and write paths are independent, each with one outstanding transaction.

---
 rtl/axi4l_ipif_pkg.sv | 24 ++
 rtl/axi4l_ipif_ack_timer.sv | 31 +++
 rtl/axi4lite_ipif.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi4lite_ipif.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_ipif_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite to IPIF bridge.
package axi4l_ipif_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Wide enough for the largest supported ack timeout (255).
    localparam int unsigned TIMER_W = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_ACK  = 2'd2,
        W_RESP = 2'd3
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_ACK  = 2'd2,
        R_RESP = 2'd3
    } r_state_e;

endpackage

// File: rtl/axi4l_ipif_ack_timer.sv
// Ack-window down-counter: load at request launch, count while waiting, flag expiry.
module axi4l_ipif_ack_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q, count_d;

    assign expired = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && !expired) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/axi4lite_ipif.sv
// AXI4-Lite slave to word-addressed IPIF register bus, one outstanding op per direction.
// Define AXI4L_IPIF_ASSERT_EN to compile protocol SVA checks (no logic change).
module axi4lite_ipif
    import axi4l_ipif_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH  = 12,
    parameter int unsigned C_DATA_WIDTH  = 32,
    parameter int unsigned C_ACK_TIMEOUT = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [C_ADDR_WIDTH-3:0]   wr_addr,
    output logic                      wr_req,
    output logic [C_DATA_WIDTH/8-1:0] wr_be,
    output logic [C_DATA_WIDTH-1:0]   wr_data,
    input  logic                      wr_ack,
    output logic [C_ADDR_WIDTH-3:0]   rd_addr,
    output logic                      rd_req,
    input  logic [C_DATA_WIDTH-1:0]   rd_data,
    input  logic                      rd_ack
);

    localparam int unsigned WA = C_ADDR_WIDTH - 2;
    localparam int unsigned SW = C_DATA_WIDTH / 8;
    localparam logic [TIMER_W-1:0] TMR_LOAD = TIMER_W'(C_ACK_TIMEOUT - 1);

    logic unused_prot;
    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // ---------------- write path ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [WA-1:0]         wr_addr_q, wr_addr_d;
    logic [SW-1:0]         wr_be_q, wr_be_d;
    logic [C_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_tmr_load, w_tmr_en, w_tmr_expired;
    logic                  aw_fire, w_fire, wr_win;

    // Readies are gated by reset so they read 0 in reset and 1 the moment it releases.
    assign s_axi_awready = !areset && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axi_wready  = !areset && (w_state_q == W_IDLE) && !w_held_q;
    assign aw_fire       = s_axi_awvalid && s_axi_awready;
    assign w_fire        = s_axi_wvalid && s_axi_wready;
    assign wr_win        = (w_state_q == W_REQ) || (w_state_q == W_ACK);

    assign wr_req        = (w_state_q == W_REQ);
    assign s_axi_bvalid  = (w_state_q == W_RESP);
    assign s_axi_bresp   = bresp_q;
    assign wr_addr       = wr_addr_q;
    assign wr_be         = wr_be_q;
    assign wr_data       = wr_data_q;

    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        wr_addr_d  = wr_addr_q;
        wr_be_d    = wr_be_q;
        wr_data_d  = wr_data_q;
        bresp_d    = bresp_q;
        w_tmr_load = 1'b0;
        w_tmr_en   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = s_axi_awaddr[C_ADDR_WIDTH-1:2];
                end
                if (w_fire) begin
                    w_held_d  = 1'b1;
                    wr_be_d   = s_axi_wstrb;
                    wr_data_d = s_axi_wdata;
                end
                if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
                    w_state_d  = W_REQ;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    w_tmr_load = 1'b1;
                end
            end
            W_REQ, W_ACK: begin
                w_tmr_en = 1'b1;
                // An ack on the final window cycle still wins over the timeout.
                if (wr_ack) begin
                    bresp_d   = RESP_OKAY;
                    w_state_d = W_RESP;
                end else if (w_tmr_expired) begin
                    bresp_d   = RESP_SLVERR;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_ACK;
                end
            end
            W_RESP: begin
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            wr_data_q <= wr_data_d;
            bresp_q   <= bresp_d;
        end
    end

    axi4l_ipif_ack_timer #(.W(TIMER_W)) u_w_timer (
        .clk      (aclk),
        .rst      (areset),
        .load     (w_tmr_load),
        .en       (w_tmr_en),
        .load_val (TMR_LOAD),
        .expired  (w_tmr_expired)
    );

    // ---------------- read path ----------------
    r_state_e              r_state_q, r_state_d;
    logic [WA-1:0]         rd_addr_q, rd_addr_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  r_tmr_load, r_tmr_en, r_tmr_expired;
    logic                  ar_fire, rd_win;

    assign s_axi_arready = !areset && (r_state_q == R_IDLE);
    assign ar_fire       = s_axi_arvalid && s_axi_arready;
    assign rd_win        = (r_state_q == R_REQ) || (r_state_q == R_ACK);

    assign rd_req        = (r_state_q == R_REQ);
    assign s_axi_rvalid  = (r_state_q == R_RESP);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign rd_addr       = rd_addr_q;

    always_comb begin
        r_state_d  = r_state_q;
        rd_addr_d  = rd_addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        r_tmr_load = 1'b0;
        r_tmr_en   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rd_addr_d  = s_axi_araddr[C_ADDR_WIDTH-1:2];
                    r_state_d  = R_REQ;
                    r_tmr_load = 1'b1;
                end
            end
            R_REQ, R_ACK: begin
                r_tmr_en = 1'b1;
                if (rd_ack) begin
                    rdata_d   = rd_data;
                    rresp_d   = RESP_OKAY;
                    r_state_d = R_RESP;
                end else if (r_tmr_expired) begin
                    rdata_d   = '0;
                    rresp_d   = RESP_SLVERR;
                    r_state_d = R_RESP;
                end else begin
                    r_state_d = R_ACK;
                end
            end
            R_RESP: begin
                if (s_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            rd_addr_q <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    axi4l_ipif_ack_timer #(.W(TIMER_W)) u_r_timer (
        .clk      (aclk),
        .rst      (areset),
        .load     (r_tmr_load),
        .en       (r_tmr_en),
        .load_val (TMR_LOAD),
        .expired  (r_tmr_expired)
    );

`ifdef AXI4L_IPIF_ASSERT_EN
    ap_awvalid_hold: assert property (@(posedge aclk) disable iff (areset)
        s_axi_awvalid && !s_axi_awready |=> s_axi_awvalid);
    ap_wvalid_hold:  assert property (@(posedge aclk) disable iff (areset)
        s_axi_wvalid && !s_axi_wready |=> s_axi_wvalid);
    ap_arvalid_hold: assert property (@(posedge aclk) disable iff (areset)
        s_axi_arvalid && !s_axi_arready |=> s_axi_arvalid);
    ap_bvalid_hold:  assert property (@(posedge aclk) disable iff (areset)
        s_axi_bvalid && !s_axi_bready |=> s_axi_bvalid);
    ap_rvalid_hold:  assert property (@(posedge aclk) disable iff (areset)
        s_axi_rvalid && !s_axi_rready |=> s_axi_rvalid);
    ap_wr_req_pulse: assert property (@(posedge aclk) disable iff (areset)
        wr_req |=> !wr_req);
    ap_rd_req_pulse: assert property (@(posedge aclk) disable iff (areset)
        rd_req |=> !rd_req);

    always @(posedge aclk) begin
        if (!areset && wr_ack && !wr_win) $warning("wr_ack outside ack window ignored");
        if (!areset && rd_ack && !rd_win) $warning("rd_ack outside ack window ignored");
    end
`else
    logic unused_win;
    assign unused_win = wr_win ^ rd_win;
`endif

endmodule

// File: tb/tb_axi4lite_ipif.sv
// Directed self-checking bench for axi4lite_ipif (default parameters, timeout 8).
module tb_axi4lite_ipif;

    logic        aclk = 1'b0;
    logic        areset;
    logic [11:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [11:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [9:0]  wr_addr;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [9:0]  rd_addr;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_ack;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi4lite_ipif dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wr_addr(wr_addr), .wr_req(wr_req), .wr_be(wr_be), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int n;
        areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;

        // Reset state
        tick(); tick();
        check("rst_awready", 32'(s_axi_awready), 0);
        check("rst_wready",  32'(s_axi_wready), 0);
        check("rst_arready", 32'(s_axi_arready), 0);
        check("rst_valids",  32'({s_axi_bvalid, s_axi_rvalid, wr_req, rd_req}), 0);
        check("rst_addrs",   32'({wr_addr, rd_addr}), 0);
        check("rst_data",    wr_data | s_axi_rdata, 0);
        check("rst_resp",    32'({s_axi_bresp, s_axi_rresp, wr_be}), 0);
        areset = 1'b0;
        #1;
        check("post_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

        // Write 1: AW and W together, ack one cycle after wr_req
        tick();
        s_axi_awaddr = 12'h3A8; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'h5; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("w1_req",     32'(wr_req), 1);
        check("w1_addr",    32'(wr_addr), 32'h0EA);
        check("w1_be",      32'(wr_be), 32'h5);
        check("w1_data",    wr_data, 32'hDEADBEEF);
        check("w1_awready", 32'(s_axi_awready), 0);
        tick();
        check("w1_req_pulse", 32'(wr_req), 0);
        check("w1_no_bvalid", 32'(s_axi_bvalid), 0);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("w1_bvalid", 32'(s_axi_bvalid), 1);
        check("w1_bresp",  32'(s_axi_bresp), 0);
        tick();
        check("w1_bvalid_hold", 32'(s_axi_bvalid), 1);
        s_axi_bready = 1'b1;
        tick();
        check("w1_bvalid_drop", 32'(s_axi_bvalid), 0);
        check("w1_idle_ready",  32'({s_axi_awready, s_axi_wready}), 32'h3);

        // Write 2: AW one cycle before W, no ack -> SLVERR after 8 cycles
        s_axi_awaddr = 12'h004; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("w2_aw_only", 32'({s_axi_awready, s_axi_wready, wr_req}), 32'h2);
        s_axi_wdata = 32'hABCDEF01; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check("w2_req",  32'(wr_req), 1);
        check("w2_addr", 32'(wr_addr), 32'h001);
        check("w2_data", wr_data, 32'hABCDEF01);
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            tick();
            n++;
        end
        check("w2_timeout_cycles", 32'(n), 8);
        check("w2_bresp", 32'(s_axi_bresp), 32'h2);
        check("w2_addr_stable", 32'(wr_addr), 32'h001);
        tick();
        check("w2_bvalid_drop", 32'(s_axi_bvalid), 0);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("w2_late_ack_ignored", 32'({s_axi_bvalid, wr_req, s_axi_awready}), 32'h1);

        // Write 3: W before AW, ack in the wr_req cycle
        s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'hC; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check("w3_w_only", 32'({s_axi_awready, s_axi_wready, wr_req}), 32'h4);
        s_axi_awaddr = 12'hFFC; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("w3_req",  32'(wr_req), 1);
        check("w3_addr", 32'(wr_addr), 32'h3FF);
        check("w3_be",   32'(wr_be), 32'hC);
        check("w3_data", wr_data, 32'h11223344);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("w3_bvalid", 32'({s_axi_bvalid, s_axi_bresp}), 32'h4);
        tick();
        check("w3_bvalid_drop", 32'(s_axi_bvalid), 0);

        // Read 1: ack in rd_req cycle
        s_axi_araddr = 12'h010; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("r1_req",     32'(rd_req), 1);
        check("r1_addr",    32'(rd_addr), 32'h004);
        check("r1_arready", 32'(s_axi_arready), 0);
        rd_ack = 1'b1; rd_data = 32'h12345678;
        tick();
        rd_ack = 1'b0; rd_data = '0;
        check("r1_rvalid", 32'(s_axi_rvalid), 1);
        check("r1_rdata",  s_axi_rdata, 32'h12345678);
        check("r1_rresp",  32'(s_axi_rresp), 0);
        check("r1_req_pulse", 32'(rd_req), 0);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("r1_rvalid_drop", 32'({s_axi_rvalid, s_axi_arready}), 32'h1);

        // Read 2: timeout, then a late ack must not disturb the response
        s_axi_araddr = 12'h020; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("r2_req", 32'({rd_req, rd_addr}), 32'h408);
        n = 0;
        while (!s_axi_rvalid && n < 20) begin
            tick();
            n++;
        end
        check("r2_timeout_cycles", 32'(n), 8);
        check("r2_rdata", s_axi_rdata, 0);
        check("r2_rresp", 32'(s_axi_rresp), 32'h2);
        rd_ack = 1'b1; rd_data = 32'hFFFFFFFF;
        tick();
        rd_ack = 1'b0; rd_data = '0;
        check("r2_late_ack_rvalid", 32'(s_axi_rvalid), 1);
        check("r2_late_ack_rdata",  s_axi_rdata, 0);
        check("r2_late_ack_rresp",  32'(s_axi_rresp), 32'h2);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("r2_rvalid_drop", 32'(s_axi_rvalid), 0);

        // Reset while waiting for wr_ack
        s_axi_awaddr = 12'h100; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("w4_req", 32'({wr_req, wr_addr}), 32'h440);
        tick();
        check("w4_in_ack", 32'({wr_req, s_axi_bvalid, s_axi_awready}), 0);
        areset = 1'b1;
        #1;
        check("w4_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 0);
        check("w4_rst_regs",    32'({wr_addr, wr_be, wr_req, s_axi_bvalid}), 0);
        check("w4_rst_data",    wr_data | s_axi_rdata, 0);
        tick();
        areset = 1'b0;
        #1;
        check("w4_release_ready", 32'({s_axi_awready, s_axi_wready}), 32'h3);
        tick();
        s_axi_awaddr = 12'h008; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h5A5A5A5A; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("w5_req",  32'({wr_req, wr_addr}), 32'h402);
        check("w5_data", wr_data, 32'h5A5A5A5A);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("w5_bresp", 32'({s_axi_bvalid, s_axi_bresp}), 32'h4);
        s_axi_bready = 1'b1;
        tick();
        check("w5_done", 32'(s_axi_bvalid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
